// File: rtl/bus_bridge_slave_uart.sv
`default_nettype none
// ============================================================================
//  Module      : bus_bridge_slave_uart
//  Description : Split-capable bus target that forwards each accepted bus
//                transaction over an 8N1 UART link to a remote UART bridge
//                master and returns the remote response on the local bus.
//                Writes complete with s_ack. Reads are split and return
//                their data through split_req / split_grant.
//
//  Ports       : clk, rst           - clock, asynchronous active-high reset
//                s_address_in(_valid), s_rw, s_data_in(_valid)
//                                   - local bus request side
//                s_data_out(_valid), s_ack, s_split_ack, s_ready
//                                   - local bus response side
//                split_req / split_grant
//                                   - re-ownership handshake for read return
//                uart_tx / uart_rx  - serial link (idle high)
//
//  Outbound frames : write = 0x57, addr_hi, addr_lo, data
//                    read  = 0x52, addr_hi, addr_lo
//  Inbound reply   : write = 0x06 (anything else counts as failure)
//                    read  = one data byte
//
//  Revision    : 1.0  initial release
// ============================================================================
module bus_bridge_slave_uart #(
    parameter int          LOCAL_ADDR_BITS = 12,
    parameter logic [15:0] REMOTE_BASE     = 16'h0000,
    parameter int          CLKS_PER_BIT    = 868,      // must be >= 4
    parameter int          TIMEOUT_CYCLES  = 2000000   // must be >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_address_in,
    input  logic        s_address_in_valid,
    input  logic [7:0]  s_data_in,
    input  logic        s_data_in_valid,
    input  logic        s_rw,
    output logic [7:0]  s_data_out,
    output logic        s_data_out_valid,
    output logic        s_ack,
    output logic        s_split_ack,
    output logic        s_ready,
    output logic        split_req,
    input  logic        split_grant,
    output logic        uart_tx,
    input  logic        uart_rx
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CW   = $clog2(CLKS_PER_BIT);
    localparam int c_HALF = CLKS_PER_BIT / 2;
    localparam int c_TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_HALF - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);

    localparam logic [15:0] c_OFFSET_MASK =
        16'((32'd1 << LOCAL_ADDR_BITS) - 32'd1);

    localparam logic [7:0] c_CMD_WRITE = 8'h57;
    localparam logic [7:0] c_CMD_READ  = 8'h52;
    localparam logic [7:0] c_RSP_ACK   = 8'h06;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] c_ST_SPLIT     = 3'd2;
    localparam logic [2:0] c_ST_SEND      = 3'd3;
    localparam logic [2:0] c_ST_WAIT_RESP = 3'd4;
    localparam logic [2:0] c_ST_DONE_W    = 3'd5;
    localparam logic [2:0] c_ST_RETURN    = 3'd6;
    localparam logic [2:0] c_ST_RDATA     = 3'd7;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;

    logic [15:0]     r_addr;
    logic            r_rw;
    logic [7:0]      r_wdata;
    logic [7:0]      r_rdata;
    logic [c_TW-1:0] r_tmo_cnt;
    logic [15:0]     w_remote_addr;
    logic            w_timeout;

    logic            r_tx_active;
    logic            r_tx_line;
    logic [8:0]      r_tx_shift;
    logic [3:0]      r_tx_bit;
    logic [c_CW-1:0] r_tx_clk;
    logic [1:0]      r_tx_idx;
    logic [1:0]      w_tx_last_idx;
    logic            w_tx_frame_done;

    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_busy;
    logic [c_CW-1:0] r_rx_clk;
    logic [3:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            r_rx_valid;
    logic [7:0]      r_rx_data;
    logic            w_rx_sample;

    // Remote address is the base plus the decoded local offset, 16-bit wrap.
    assign w_remote_addr = REMOTE_BASE + (s_address_in & c_OFFSET_MASK);

    // Byte k of the outbound frame for the latched transaction.
    function automatic logic [7:0] f_frame_byte(
        input logic [1:0]  idx,
        input logic        rw,
        input logic [15:0] addr,
        input logic [7:0]  wdata
    );
        logic [7:0] v;
        case (idx)
            2'd0:    v = rw ? c_CMD_WRITE : c_CMD_READ;
            2'd1:    v = addr[15:8];
            2'd2:    v = addr[7:0];
            default: v = wdata;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (s_address_in_valid) begin
                    if (s_rw) begin
                        w_state_nxt = s_data_in_valid ? c_ST_SEND : c_ST_WAIT_DATA;
                    end else begin
                        w_state_nxt = c_ST_SPLIT;
                    end
                end
            end
            c_ST_WAIT_DATA: begin
                if (s_data_in_valid) begin
                    w_state_nxt = c_ST_SEND;
                end
            end
            c_ST_SPLIT: begin
                w_state_nxt = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_tx_frame_done) begin
                    w_state_nxt = c_ST_WAIT_RESP;
                end
            end
            c_ST_WAIT_RESP: begin
                // A received byte takes priority over a coincident timeout.
                if (r_rx_valid) begin
                    if (r_rw) begin
                        w_state_nxt = (r_rx_data == c_RSP_ACK) ? c_ST_DONE_W : c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_RETURN;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = r_rw ? c_ST_IDLE : c_ST_RETURN;
                end
            end
            c_ST_DONE_W: begin
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_RETURN: begin
                if (split_grant) begin
                    w_state_nxt = c_ST_RDATA;
                end
            end
            c_ST_RDATA: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // s_ready is gated by rst so it reads 0 for the whole reset window.
        s_ready          = (r_state == c_ST_IDLE) && !rst;
        s_split_ack      = (r_state == c_ST_SPLIT);
        s_ack            = (r_state == c_ST_DONE_W);
        split_req        = (r_state == c_ST_RETURN);
        s_data_out_valid = (r_state == c_ST_RDATA);
        s_data_out       = r_rdata;
        uart_tx          = r_tx_line;
    end

    // ------------------------------------------------------------------
    // Transaction datapath
    // ------------------------------------------------------------------
    assign w_timeout = (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (r_state == c_ST_IDLE && s_address_in_valid) begin
                r_addr <= w_remote_addr;
                r_rw   <= s_rw;
                if (s_rw && s_data_in_valid) begin
                    r_wdata <= s_data_in;
                end
            end
            if (r_state == c_ST_WAIT_DATA && s_data_in_valid) begin
                r_wdata <= s_data_in;
            end
            if (r_state == c_ST_WAIT_RESP && !r_rw) begin
                if (r_rx_valid) begin
                    r_rdata <= r_rx_data;
                end else if (w_timeout) begin
                    r_rdata <= 8'hFF;
                end
            end
            if (r_state == c_ST_SEND) begin
                r_tmo_cnt <= '0;
            end else if (r_state == c_ST_WAIT_RESP) begin
                r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter: sends the whole frame back to back while in SEND.
    // r_tx_bit: 0 = start, 1..8 = data, 9 = stop.
    // ------------------------------------------------------------------
    assign w_tx_last_idx   = r_rw ? 2'd3 : 2'd2;
    assign w_tx_frame_done = r_tx_active && (r_tx_clk == c_BIT_LAST) &&
                             (r_tx_bit == 4'd9) && (r_tx_idx == w_tx_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_active <= 1'b0;
            r_tx_line   <= 1'b1;
            r_tx_shift  <= '0;
            r_tx_bit    <= '0;
            r_tx_clk    <= '0;
            r_tx_idx    <= '0;
        end else if (!r_tx_active) begin
            r_tx_line <= 1'b1;
            r_tx_clk  <= '0;
            r_tx_bit  <= '0;
            if (r_state == c_ST_SEND) begin
                r_tx_active <= 1'b1;
                r_tx_idx    <= 2'd0;
                r_tx_shift  <= {1'b1, f_frame_byte(2'd0, r_rw, r_addr, r_wdata)};
                r_tx_line   <= 1'b0;
            end
        end else if (r_tx_clk == c_BIT_LAST) begin
            r_tx_clk <= '0;
            if (r_tx_bit == 4'd9) begin
                if (r_tx_idx == w_tx_last_idx) begin
                    r_tx_active <= 1'b0;
                    r_tx_line   <= 1'b1;
                end else begin
                    // Next byte's start bit directly follows this stop bit.
                    r_tx_idx   <= r_tx_idx + 2'd1;
                    r_tx_shift <= {1'b1, f_frame_byte(r_tx_idx + 2'd1, r_rw, r_addr, r_wdata)};
                    r_tx_bit   <= 4'd0;
                    r_tx_line  <= 1'b0;
                end
            end else begin
                // Shifting in ones makes the stop bit fall out after the data.
                r_tx_line  <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bit   <= r_tx_bit + 4'd1;
            end
        end else begin
            r_tx_clk <= r_tx_clk + c_CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // UART receiver. The start edge is taken from the synchroniser pair so
    // that counting begins as r_rx_s2 falls; all samples use r_rx_s2.
    // ------------------------------------------------------------------
    assign w_rx_sample = r_rx_busy &&
                         ((r_rx_bit == 4'd0) ? (r_rx_clk == c_HALF_LAST)
                                             : (r_rx_clk == c_BIT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_clk   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_valid <= 1'b0;
            if (!r_rx_busy) begin
                r_rx_clk <= '0;
                r_rx_bit <= '0;
                if (r_rx_s2 && !r_rx_s1) begin
                    r_rx_busy <= 1'b1;
                end
            end else if (w_rx_sample) begin
                r_rx_clk <= '0;
                if (r_rx_bit == 4'd0) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_rx_s2) begin
                        r_rx_busy <= 1'b0;
                    end else begin
                        r_rx_bit <= 4'd1;
                    end
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_s2) begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                    end
                end else begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 4'd1;
                end
            end else begin
                r_rx_clk <= r_rx_clk + c_CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_bridge_slave_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_bridge_slave_uart
//  Description : Scoreboard bench for bus_bridge_slave_uart. Stimulus pushes
//                expected UART bytes and bus events into queues; independent
//                monitors decode uart_tx and watch the bus strobes, popping
//                and comparing as the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_bridge_slave_uart;

    localparam int CPB = 4;
    localparam int TMO = 100;

    localparam int EV_ACK   = 0;
    localparam int EV_SPLIT = 1;
    localparam int EV_RDATA = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_address_in;
    logic        s_address_in_valid;
    logic [7:0]  s_data_in;
    logic        s_data_in_valid;
    logic        s_rw;
    logic [7:0]  s_data_out;
    logic        s_data_out_valid;
    logic        s_ack;
    logic        s_split_ack;
    logic        s_ready;
    logic        split_req;
    logic        split_grant;
    logic        uart_tx;
    logic        uart_rx;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$];
    evt_t       evq[$];

    always #5 clk = ~clk;

    bus_bridge_slave_uart #(
        .LOCAL_ADDR_BITS (12),
        .REMOTE_BASE     (16'h4000),
        .CLKS_PER_BIT    (CPB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_address_in       (s_address_in),
        .s_address_in_valid (s_address_in_valid),
        .s_data_in          (s_data_in),
        .s_data_in_valid    (s_data_in_valid),
        .s_rw               (s_rw),
        .s_data_out         (s_data_out),
        .s_data_out_valid   (s_data_out_valid),
        .s_ack              (s_ack),
        .s_split_ack        (s_split_ack),
        .s_ready            (s_ready),
        .split_req          (split_req),
        .split_grant        (split_grant),
        .uart_tx            (uart_tx),
        .uart_rx            (uart_rx)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        txq.push_back(b);
    endtask

    task automatic push_evt(input int kind, input logic [7:0] d);
        evt_t e;
        e.kind = kind;
        e.data = d;
        evq.push_back(e);
    endtask

    task automatic check_evt(input int kind, input logic [7:0] d);
        evt_t e;
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL bus_event: got kind=%0d data=%02h, required no event", kind, d);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.data !== d) begin
                errors++;
                $display("FAIL bus_event: got kind=%0d data=%02h, required kind=%0d data=%02h",
                         kind, d, e.kind, e.data);
            end
        end
    endtask

    task automatic check_tx(input logic [7:0] b, input logic sb);
        logic [7:0] e;
        checks++;
        if (txq.size() == 0) begin
            errors++;
            $display("FAIL tx_byte: got %02h (stop=%0b), required no byte", b, sb);
        end else begin
            e = txq.pop_front();
            if (b !== e || sb !== 1'b1) begin
                errors++;
                $display("FAIL tx_byte: got %02h (stop=%0b), required %02h (stop=1)", b, sb, e);
            end
        end
    endtask

    // Waits n falling edges; stops waiting as soon as reset is seen.
    task automatic wait_neg(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            if (!ab) begin
                @(negedge clk);
                if (rst) ab = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (s_ack)            check_evt(EV_ACK,   8'h00);
            if (s_split_ack)      check_evt(EV_SPLIT, 8'h00);
            if (s_data_out_valid) check_evt(EV_RDATA, s_data_out);
        end
    end

    initial begin : tx_mon
        logic [7:0] b;
        logic       sb;
        bit         ab;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx == 1'b0) begin
                ab = 1'b0;
                wait_neg(CPB / 2, ab);
                for (int i = 0; i < 8; i++) begin
                    wait_neg(CPB, ab);
                    b[i] = uart_tx;
                end
                wait_neg(CPB, ab);
                sb = uart_tx;
                if (!ab) check_tx(b, sb);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic bus_cmd(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic dv);
        @(posedge clk); #1;
        s_address_in       = a;
        s_address_in_valid = 1'b1;
        s_rw               = rw;
        s_data_in          = d;
        s_data_in_valid    = dv;
        @(posedge clk); #1;
        s_address_in_valid = 1'b0;
        s_data_in_valid    = 1'b0;
    endtask

    task automatic bus_data(input logic [7:0] d);
        @(posedge clk); #1;
        s_data_in       = d;
        s_data_in_valid = 1'b1;
        @(posedge clk); #1;
        s_data_in_valid = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 uart_rx = stop;
        repeat (CPB) @(posedge clk);
        #1 uart_rx = 1'b1;
    endtask

    task automatic wait_tx_done(input string name);
        int n = 0;
        while (txq.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txq.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d bytes still pending, required 0", name, txq.size());
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, s_ready, 1);
    endtask

    task automatic wait_tx_start(input string name);
        int n = 0;
        while (uart_tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, uart_tx, 0);
    endtask

    // Waits for split_req; returns cycles waited.
    task automatic wait_split(input string name, output int n);
        n = 0;
        while (!split_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, split_req, 1);
    endtask

    task automatic grant_return(input int hold, input logic [7:0] d);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            @(negedge clk);
            chk("split_req_held", split_req, 1);
        end
        push_evt(EV_RDATA, d);
        @(posedge clk); #1 split_grant = 1'b1;
        @(posedge clk); #1 split_grant = 1'b0;
        @(negedge clk);
        chk("split_req_dropped", split_req, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst = 1'b1;
        s_address_in = '0; s_address_in_valid = 1'b0;
        s_data_in = '0; s_data_in_valid = 1'b0; s_rw = 1'b0;
        split_grant = 1'b0; uart_rx = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {s_ready, s_ack, s_split_ack, split_req, s_data_out_valid, uart_tx, s_data_out},
            {6'b000001, 8'h00});
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", s_ready, 1);

        // Write 0x0123 <- 0xA5, data with address, remote ack
        push_tx(8'h57); push_tx(8'h41); push_tx(8'h23); push_tx(8'hA5);
        push_evt(EV_ACK, 8'h00);
        bus_cmd(16'h0123, 1'b1, 8'hA5, 1'b1);
        wait_tx_done("w1_frame");
        rx_send(8'h06, 1'b1);
        wait_ready("w1_ready");

        // Read 0x0456, remote returns 0x3C, grant delayed 5 cycles
        push_tx(8'h52); push_tx(8'h44); push_tx(8'h56);
        push_evt(EV_SPLIT, 8'h00);
        bus_cmd(16'h0456, 1'b0, 8'h00, 1'b0);
        wait_tx_done("r1_frame");
        rx_send(8'h3C, 1'b1);
        wait_split("r1_split_req", n);
        grant_return(5, 8'h3C);
        wait_ready("r1_ready");

        // Read 0x0010 with no reply: timeout returns 0xFF
        push_tx(8'h52); push_tx(8'h40); push_tx(8'h10);
        push_evt(EV_SPLIT, 8'h00);
        bus_cmd(16'h0010, 1'b0, 8'h00, 1'b0);
        wait_tx_done("r2_frame");
        wait_split("r2_split_req", n);
        checks++;
        if (n < 95 || n > 110) begin
            errors++;
            $display("FAIL r2_timeout_cycles: got %0d, required 95..110", n);
        end
        grant_return(0, 8'hFF);
        wait_ready("r2_ready");

        // Write with upper address bits outside the window, reply 0x15: no ack
        push_tx(8'h57); push_tx(8'h40); push_tx(8'hFF); push_tx(8'h3B);
        bus_cmd(16'hF0FF, 1'b1, 8'h3B, 1'b1);
        wait_tx_done("w2_frame");
        rx_send(8'h15, 1'b1);
        wait_ready("w2_ready");
        repeat (20) @(negedge clk);

        // Write with separate data phase, stray request during SEND
        push_tx(8'h57); push_tx(8'h42); push_tx(8'h00); push_tx(8'h11);
        push_evt(EV_ACK, 8'h00);
        bus_cmd(16'h0200, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        chk("w3_wait_data_not_ready", s_ready, 0);
        bus_data(8'h11);
        wait_tx_start("w3_tx_started");
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("w3_send_not_ready", s_ready, 0);
        bus_cmd(16'h0333, 1'b0, 8'h99, 1'b1);
        wait_tx_done("w3_frame");
        rx_send(8'h06, 1'b1);
        wait_ready("w3_ready");
        repeat (60) @(negedge clk);

        // Reset in the middle of the first TX byte
        bus_cmd(16'h0001, 1'b1, 8'h77, 1'b1);
        wait_tx_start("w4_tx_started");
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_tx_line", uart_tx, 1);
        chk("rst_mid_outputs",
            {s_ready, s_ack, s_split_ack, split_req, s_data_out_valid, s_data_out},
            {5'b00000, 8'h00});
        txq.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("ready_after_mid_reset", s_ready, 1);
        push_tx(8'h57); push_tx(8'h4A); push_tx(8'hBC); push_tx(8'h5A);
        push_evt(EV_ACK, 8'h00);
        bus_cmd(16'h0ABC, 1'b1, 8'h5A, 1'b1);
        wait_tx_done("w5_frame");
        rx_send(8'h06, 1'b1);
        wait_ready("w5_ready");

        // Reply with a bad stop bit is dropped; the following 0x06 completes
        push_tx(8'h57); push_tx(8'h40); push_tx(8'h02); push_tx(8'hC3);
        push_evt(EV_ACK, 8'h00);
        bus_cmd(16'h0002, 1'b1, 8'hC3, 1'b1);
        wait_tx_done("w6_frame");
        rx_send(8'h15, 1'b0);
        repeat (CPB) @(posedge clk);
        rx_send(8'h06, 1'b1);
        wait_ready("w6_ready");

        // Drain and confirm nothing expected is left outstanding
        repeat (50) @(negedge clk);
        chk("tx_queue_empty", txq.size(), 0);
        chk("event_queue_empty", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
